ctrl_word_encoder: RTL and testbench
====================================

// Module: ctrl_word_encoder
// PURPOSE
//  Inverse of the instruction control decoder. Accepts the 10-bit control bundle at the writeback/trace point,
//  maps it back to the 2-bit opcode and flags illegal bundles. Buffers results in a small FIFO for the debug/trace port.
//  Keeps saturating per-opcode retire counters and an illegal-bundle counter.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >=2
//  SEQ_W   8   sequence-tag width; the tag wraps
//  CNT_W   16  width of each statistics counter; counters saturate
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high
//  clear      in   1      sync flush: empties the FIFO, zeroes counters and seq
//  in_valid   in   1      control bundle present
//  in_ready   out  1      = !full && !clear
//  in_cw      in   10     {RegDst,RegWrite,ALUSrc,Branch,MemRead,MemWrite,MemtoReg,ALUOp,DCFront,DCBack}
//  out_valid  out  1      FIFO not empty
//  out_ready  in   1      consumer accepts the head entry
//  out_op     out  2      recovered opcode (0 R-type, 1 load, 2 store, 3 branch)
//  out_ill    out  1      bundle matched no legal pattern
//  out_seq    out  SEQ_W  tag of the entry
//  cnt_op0..cnt_op3  out  CNT_W  accepted legal bundles per opcode
//  cnt_ill    out  CNT_W  accepted illegal bundles
// BEHAVIOUR
//  - Interface: one clock, clk. Reset is asynchronous and active-high, port reset.
//  - Reset: FIFO empty, out_valid=0, out_op=0, out_ill=0, out_seq=0, all counters=0, seq counter=0.
//  - Encoding, exact 10-bit match:
//      10'h305 -> op 0
//      10'h1AD -> op 1
//      10'h096 -> op 2
//      10'h043 -> op 3
//      anything else -> op 0 with ill=1.
//  - Accept occurs when in_valid && in_ready. On accept:
//      - push {op, ill, seq}; seq increments mod 2^SEQ_W.
//      - increment the matching counter (cnt_op[op], or cnt_ill if illegal), holding at 2^CNT_W-1.
//  - Pop occurs when out_valid && out_ready. Outputs always show the head entry; the head is 0 when empty.
//  - Latency: an accept into an empty FIFO raises out_valid on the next edge. There is no same-cycle bypass.
//  - Push and pop in the same cycle when not full: occupancy is unchanged and both take effect.
//  - Full: in_ready=0, including in a cycle where a pop also occurs. There is no pass-through when full.
//  - Empty: a pop request is ignored.
//  - clear has priority over everything. That cycle: no accept (in_ready=0); the pop is ignored.
//    Next cycle: FIFO empty, counters=0, seq=0.
//  - Pointers are log2(DEPTH) bits plus one wrap bit:
//      full  = (ptrs differ only in the MSB)
//      empty = (ptrs equal)
//  - Reset asserted mid-stream drops all entries immediately (asynchronous); no partial state survives.
// STRUCTURE
//  - Shared package ctrl_pkg:
//      - opcode localparams OP_RTYPE=0, OP_LOAD=1, OP_STORE=2, OP_BRANCH=3
//      - CW_RTYPE/CW_LOAD/CW_STORE/CW_BRANCH constants, also used by the forward decoder.
//      - control-bundle bit indices.
//  - Sub-module ctrl_fifo: a parameterised sync FIFO with push, pop, full, empty and clr. The entry width is 3+SEQ_W.
//  - Encoder match logic and counters live in the top module.
// TESTING
//  - Reset, then push 10'h305, 10'h1AD, 10'h096, 10'h043 back-to-back with out_ready=1.
//    -> out_op = 0,1,2,3; ill=0; seq=0..3; each cnt_op=1.
//  - Push 10'h000, then 10'h3FF.
//    -> ill=1, op=0 both times; cnt_ill=2; op counters unchanged.
//  - Hold out_ready=0 and push 5 words with DEPTH=4.
//    -> in_ready drops after the 4th accept; the 5th is held.
//    -> Then out_ready=1 for one cycle -> 5th accepted the following cycle, order preserved.
//  - Continuous push and pop for 300 words with SEQ_W=8.
//    -> seq wraps 255 -> 0; occupancy stays at 1; no drop and no duplicate.
//  - Force cnt_op1 to 0xFFFF (CNT_W=16) via 2^16 loads, or use a reduced CNT_W=3 build.
//    -> the counter holds at its maximum.
//  - Assert clear with 3 entries queued and in_valid=1.
//    -> next cycle out_valid=0, counters=0, next accepted word has seq=0.
//  - Assert reset asynchronously between clock edges.
//    -> outputs zero before the next edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-word definitions: opcodes, canonical control bundles and bundle bit positions.
// The forward decoder and the trace-side encoder both use these.
package ctrl_pkg;

    localparam logic [1:0] OP_RTYPE  = 2'd0;
    localparam logic [1:0] OP_LOAD   = 2'd1;
    localparam logic [1:0] OP_STORE  = 2'd2;
    localparam logic [1:0] OP_BRANCH = 2'd3;

    localparam logic [9:0] CW_RTYPE  = 10'h305;
    localparam logic [9:0] CW_LOAD   = 10'h1AD;
    localparam logic [9:0] CW_STORE  = 10'h096;
    localparam logic [9:0] CW_BRANCH = 10'h043;

    // Bit positions inside the 10-bit bundle, MSB first.
    localparam int unsigned CWB_REGDST   = 9;
    localparam int unsigned CWB_REGWRITE = 8;
    localparam int unsigned CWB_ALUSRC   = 7;
    localparam int unsigned CWB_BRANCH   = 6;
    localparam int unsigned CWB_MEMREAD  = 5;
    localparam int unsigned CWB_MEMWRITE = 4;
    localparam int unsigned CWB_MEMTOREG = 3;
    localparam int unsigned CWB_ALUOP    = 2;
    localparam int unsigned CWB_DCFRONT  = 1;
    localparam int unsigned CWB_DCBACK   = 0;

    typedef struct packed {
        logic [1:0] op;
        logic       ill;
    } enc_t;

    function automatic enc_t cw_encode(input logic [9:0] cw);
        enc_t e;
        e = '{op: OP_RTYPE, ill: 1'b0};
        case (cw)
            CW_RTYPE:  e.op = OP_RTYPE;
            CW_LOAD:   e.op = OP_LOAD;
            CW_STORE:  e.op = OP_STORE;
            CW_BRANCH: e.op = OP_BRANCH;
            default:   e.ill = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ctrl_fifo.sv
// Synchronous FIFO with wrap-bit pointers, synchronous flush and a zero head when empty.
module ctrl_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wptr, rptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push, do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ctrl_word_encoder.sv
// Maps writeback control bundles back to opcodes, queues {op, ill, seq} for the trace port
// and keeps saturating per-opcode and illegal-bundle counters.
module ctrl_word_encoder
    import ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SEQ_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_op,
    output logic             out_ill,
    output logic [SEQ_W-1:0] out_seq,
    output logic [CNT_W-1:0] cnt_op0,
    output logic [CNT_W-1:0] cnt_op1,
    output logic [CNT_W-1:0] cnt_op2,
    output logic [CNT_W-1:0] cnt_op3,
    output logic [CNT_W-1:0] cnt_ill
);
    localparam int unsigned EW = 3 + SEQ_W;

    enc_t             enc;
    logic             full, empty, accept, pop;
    logic [SEQ_W-1:0] seq;
    logic [EW-1:0]    head;
    logic [4:0]       hit;
    logic [CNT_W-1:0] cnt [5];

    assign enc       = cw_encode(in_cw);
    assign in_ready  = !full && !clear;
    assign accept    = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_ready && out_valid && !clear;

    ctrl_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .push  (accept),
        .pop   (pop),
        .din   ({enc.op, enc.ill, seq}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign {out_op, out_ill, out_seq} = head;

    // Slot 4 counts illegal bundles; slots 0..3 count legal bundles by opcode.
    always_comb begin
        hit = '0;
        if (enc.ill) hit[4] = 1'b1;
        else         hit[enc.op] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq <= '0;
            for (int unsigned i = 0; i < 5; i++) cnt[i] <= '0;
        end else if (clear) begin
            seq <= '0;
            for (int unsigned i = 0; i < 5; i++) cnt[i] <= '0;
        end else if (accept) begin
            seq <= seq + 1'b1;
            for (int unsigned i = 0; i < 5; i++)
                if (hit[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
        end
    end

    assign cnt_op0 = cnt[0];
    assign cnt_op1 = cnt[1];
    assign cnt_op2 = cnt[2];
    assign cnt_op3 = cnt[3];
    assign cnt_ill = cnt[4];

endmodule

// File: tb/tb_ctrl_word_encoder.sv
// Bench for ctrl_word_encoder: queue-based reference model checked every cycle on a default
// build and a CNT_W=3 build driven in lockstep, plus directed literal checks.
module tb_ctrl_word_encoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SEQ_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [9:0] in_cw = '0;

    logic        in_ready, out_valid, out_ill;
    logic [1:0]  out_op;
    logic [7:0]  out_seq;
    logic [15:0] c0, c1, c2, c3, ci;

    logic        in_ready3, out_valid3, out_ill3;
    logic [1:0]  out_op3;
    logic [7:0]  out_seq3;
    logic [2:0]  s0, s1, s2, s3, si;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int op;
        int ill;
        int seq;
    } ent_t;

    ent_t        mq[$];
    ent_t        dlog[$];
    int unsigned mcnt[5];
    int          mseq;

    always #5 clk = ~clk;

    ctrl_word_encoder #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_cw(in_cw), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_ill(out_ill), .out_seq(out_seq), .cnt_op0(c0), .cnt_op1(c1), .cnt_op2(c2),
        .cnt_op3(c3), .cnt_ill(ci)
    );

    ctrl_word_encoder #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready3),
        .in_cw(in_cw), .out_valid(out_valid3), .out_ready(out_ready), .out_op(out_op3),
        .out_ill(out_ill3), .out_seq(out_seq3), .cnt_op0(s0), .cnt_op1(s1), .cnt_op2(s2),
        .cnt_op3(s3), .cnt_ill(si)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t model_encode(input logic [9:0] cw, input int s);
        logic [9:0] legal [4];
        ent_t e;
        legal = '{10'h305, 10'h1AD, 10'h096, 10'h043};
        e = '{op: 0, ill: 1, seq: s};
        for (int k = 0; k < 4; k++)
            if (cw == legal[k]) begin
                e.op  = k;
                e.ill = 0;
            end
        return e;
    endfunction

    function automatic logic [31:0] sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference model: advances on each edge from the inputs the DUT saw.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            mseq = 0;
            for (int k = 0; k < 5; k++) mcnt[k] = 0;
        end else if (clear) begin
            mq.delete();
            mseq = 0;
            for (int k = 0; k < 5; k++) mcnt[k] = 0;
        end else begin
            ent_t e;
            bit acc, popq;
            acc  = in_valid && (mq.size() < DEPTH);
            popq = out_ready && (mq.size() > 0);
            if (out_ready && out_valid) dlog.push_back('{op: out_op, ill: out_ill, seq: out_seq});
            if (popq) void'(mq.pop_front());
            if (acc) begin
                e = model_encode(in_cw, mseq);
                mq.push_back(e);
                mseq = (mseq + 1) % 256;
                if (e.ill != 0) mcnt[4]++;
                else mcnt[e.op]++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            int ev, eop, eill, eseq, erdy;
            ev = (mq.size() > 0);
            eop = 0; eill = 0; eseq = 0;
            if (ev != 0) begin
                eop = mq[0].op; eill = mq[0].ill; eseq = mq[0].seq;
            end
            erdy = (mq.size() < DEPTH) && !clear;
            chk("out_valid", out_valid, ev);
            chk("out_op", out_op, eop);
            chk("out_ill", out_ill, eill);
            chk("out_seq", out_seq, eseq);
            chk("in_ready", in_ready, erdy);
            chk("in_ready3", in_ready3, erdy);
            chk("out_seq3", out_seq3, eseq);
            chk("cnt_op0", c0, sat(mcnt[0], 65535));
            chk("cnt_op1", c1, sat(mcnt[1], 65535));
            chk("cnt_op2", c2, sat(mcnt[2], 65535));
            chk("cnt_op3", c3, sat(mcnt[3], 65535));
            chk("cnt_ill", ci, sat(mcnt[4], 65535));
            chk("sat_op0", s0, sat(mcnt[0], 7));
            chk("sat_op1", s1, sat(mcnt[1], 7));
            chk("sat_op2", s2, sat(mcnt[2], 7));
            chk("sat_op3", s3, sat(mcnt[3], 7));
            chk("sat_ill", si, sat(mcnt[4], 7));
        end
    end

    task automatic cyc(input logic v, input logic [9:0] cw, input logic ordy, input logic clr);
        @(negedge clk);
        #1;
        in_valid  = v;
        in_cw     = cw;
        out_ready = ordy;
        clear     = clr;
    endtask

    function automatic logic [9:0] pick();
        logic [9:0] w;
        case ($urandom_range(0, 5))
            0: w = 10'h305;
            1: w = 10'h1AD;
            2: w = 10'h096;
            3: w = 10'h043;
            4: w = 10'($urandom);
            default: w = 10'h000;
        endcase
        return w;
    endfunction

    initial begin
        logic [9:0] words [5];
        words = '{10'h305, 10'h1AD, 10'h096, 10'h043, 10'h305};

        #23 reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_seq", out_seq, 0);
        chk("rst_cnt_op0", c0, 0);
        chk("rst_cnt_ill", ci, 0);

        // Legal words back to back.
        for (int k = 0; k < 4; k++) cyc(1'b1, words[k], 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 10'h000, 1'b1, 1'b0);
        chk("log_size_a", dlog.size(), 4);
        for (int k = 0; k < 4 && k < dlog.size(); k++) begin
            chk("legal_op", dlog[k].op, k);
            chk("legal_ill", dlog[k].ill, 0);
            chk("legal_seq", dlog[k].seq, k);
        end
        chk("lit_cnt0", c0, 1);
        chk("lit_cnt1", c1, 1);
        chk("lit_cnt2", c2, 1);
        chk("lit_cnt3", c3, 1);

        // Illegal words.
        cyc(1'b1, 10'h000, 1'b1, 1'b0);
        cyc(1'b1, 10'h3FF, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 10'h000, 1'b1, 1'b0);
        chk("lit_cnt_ill", ci, 2);
        chk("lit_cnt0_hold", c0, 1);
        if (dlog.size() >= 6) begin
            chk("ill_a", {dlog[4].op, dlog[4].ill, dlog[4].seq}, {32'd0, 32'd1, 32'd4});
            chk("ill_b", {dlog[5].op, dlog[5].ill, dlog[5].seq}, {32'd0, 32'd1, 32'd5});
        end else chk("log_size_b", dlog.size(), 6);

        // Fill to full with the consumer stalled.
        for (int k = 0; k < 4; k++) cyc(1'b1, words[k], 1'b0, 1'b0);
        cyc(1'b1, words[4], 1'b0, 1'b0);
        #2 chk("full_ready_a", in_ready, 0);
        cyc(1'b1, words[4], 1'b0, 1'b0);
        #2 chk("full_ready_b", in_ready, 0);
        cyc(1'b1, words[4], 1'b1, 1'b0);
        #2 chk("full_pop_ready", in_ready, 0);
        cyc(1'b1, words[4], 1'b0, 1'b0);
        #2 chk("after_pop_ready", in_ready, 1);
        cyc(1'b0, 10'h000, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) cyc(1'b0, 10'h000, 1'b1, 1'b0);
        chk("log_size_c", dlog.size(), 11);
        for (int k = 0; k < 5 && 6 + k < dlog.size(); k++) begin
            chk("order_op", dlog[6 + k].op, (k == 4) ? 0 : k);
            chk("order_seq", dlog[6 + k].seq, 6 + k);
        end

        // Continuous streaming across the seq wrap.
        for (int k = 0; k < 300; k++) cyc(1'b1, (k % 4 == 1) ? 10'h1AD : pick(), 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) cyc(1'b0, 10'h000, 1'b1, 1'b0);
        chk("log_size_d", dlog.size(), 311);
        if (dlog.size() >= 257) begin
            chk("wrap_255", dlog[255].seq, 255);
            chk("wrap_0", dlog[256].seq, 0);
        end
        chk("sat3_op1", s1, 7);

        // Clear with entries queued and a word offered.
        for (int k = 0; k < 3; k++) cyc(1'b1, 10'h305, 1'b0, 1'b0);
        cyc(1'b1, 10'h1AD, 1'b1, 1'b1);
        #2 chk("clear_ready", in_ready, 0);
        cyc(1'b0, 10'h000, 1'b0, 1'b0);
        #2 chk("clear_valid", out_valid, 0);
        chk("clear_cnt0", c0, 0);
        chk("clear_cnt1", c1, 0);
        cyc(1'b1, 10'h096, 1'b0, 1'b0);
        cyc(1'b0, 10'h000, 1'b1, 1'b0);
        #2 chk("post_clear_seq", out_seq, 0);
        chk("post_clear_op", out_op, 2);

        // Random traffic with occasional clears.
        for (int k = 0; k < 400; k++)
            cyc(1'($urandom_range(0, 3) != 0), pick(), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 39) == 0));

        // Asynchronous reset between edges with entries queued.
        for (int k = 0; k < 3; k++) cyc(1'b1, 10'h043, 1'b0, 1'b0);
        cyc(1'b0, 10'h000, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_op", out_op, 0);
        chk("arst_seq", out_seq, 0);
        chk("arst_cnt3", c3, 0);
        chk("arst_ready", in_ready, 1);
        #10 reset = 1'b0;
        for (int k = 0; k < 20; k++) cyc(1'b1, pick(), 1'($urandom_range(0, 1)), 1'b0);
        for (int k = 0; k < 6; k++) cyc(1'b0, 10'h000, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
